// File: rtl/seq_stage_controller.sv
// Stage sequencer for the sequential Y86-64 core: walks each instruction
// through its stages, owns the PC, and reports status and retired count.
module seq_stage_controller #(
  parameter logic [63:0] RESET_PC    = 64'h0,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        fetch_req,
  input  logic        fetch_ack,
  input  logic        fetch_err,
  input  logic        instr_valid,
  input  logic [3:0]  icode,
  input  logic        Cnd,
  input  logic [63:0] valC,
  input  logic [63:0] valM,
  input  logic [63:0] valP,
  output logic        dmem_req,
  output logic        dmem_wr,
  output logic        dmem_wdata_sel,
  input  logic        dmem_ack,
  input  logic        dmem_err,
  output logic        cc_we,
  output logic        rf_we,
  output logic [2:0]  stage,
  output logic [63:0] pc,
  output logic [2:0]  stat,
  output logic [31:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_PCUPD     = 3'd6,
    S_HALTED    = 3'd7
  } state_t;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;
  localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

  function automatic logic uses_mem(input logic [3:0] ic);
    case (ic)
      4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB: uses_mem = 1'b1;
      default:                            uses_mem = 1'b0;
    endcase
  endfunction

  function automatic logic mem_write(input logic [3:0] ic);
    case (ic)
      4'h4, 4'h8, 4'hA: mem_write = 1'b1;
      default:          mem_write = 1'b0;
    endcase
  endfunction

  function automatic logic reg_write(input logic [3:0] ic, input logic c);
    case (ic)
      4'h3, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB: reg_write = 1'b1;
      4'h2:                                     reg_write = c;
      default:                                  reg_write = 1'b0;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [2:0]  stat_q, stat_d;
  logic [31:0] cnt_q, cnt_d;
  logic [3:0]  icode_q, icode_d;
  logic [7:0]  tmo_q, tmo_d;
  logic        fetch_req_q, fetch_req_d;
  logic        dmem_req_q, dmem_req_d;
  logic        dmem_wr_q, dmem_wr_d;
  logic        wsel_q, wsel_d;
  logic        cc_we_q, cc_we_d;
  logic        rf_we_q, rf_we_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      stat_q      <= STAT_AOK;
      cnt_q       <= '0;
      icode_q     <= '0;
      tmo_q       <= '0;
      fetch_req_q <= 1'b0;
      dmem_req_q  <= 1'b0;
      dmem_wr_q   <= 1'b0;
      wsel_q      <= 1'b0;
      cc_we_q     <= 1'b0;
      rf_we_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      stat_q      <= stat_d;
      cnt_q       <= cnt_d;
      icode_q     <= icode_d;
      tmo_q       <= tmo_d;
      fetch_req_q <= fetch_req_d;
      dmem_req_q  <= dmem_req_d;
      dmem_wr_q   <= dmem_wr_d;
      wsel_q      <= wsel_d;
      cc_we_q     <= cc_we_d;
      rf_we_q     <= rf_we_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    stat_d  = stat_q;
    cnt_d   = cnt_q;
    icode_d = icode_q;
    tmo_d   = '0;

    case (state_q)
      S_IDLE: if (start) state_d = S_FETCH;
      S_FETCH: begin
        if (fetch_ack) begin
          icode_d = icode;
          if (fetch_err) begin
            stat_d  = STAT_ADR;
            state_d = S_HALTED;
          end else if (!instr_valid) begin
            stat_d  = STAT_INS;
            state_d = S_HALTED;
          end else if (icode == 4'h0) begin
            stat_d  = STAT_HLT;
            state_d = S_HALTED;
          end else begin
            state_d = S_DECODE;
          end
        end else if (tmo_q == TMO_LAST) begin
          stat_d  = STAT_ADR;
          state_d = S_HALTED;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      S_DECODE:  state_d = S_EXECUTE;
      S_EXECUTE: state_d = uses_mem(icode_q) ? S_MEMORY : S_WRITEBACK;
      S_MEMORY: begin
        if (dmem_ack) begin
          if (dmem_err) begin
            stat_d  = STAT_ADR;
            state_d = S_HALTED;
          end else begin
            state_d = S_WRITEBACK;
          end
        end else if (tmo_q == TMO_LAST) begin
          stat_d  = STAT_ADR;
          state_d = S_HALTED;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      S_WRITEBACK: state_d = S_PCUPD;
      S_PCUPD: begin
        if ((icode_q == 4'h7 && Cnd) || icode_q == 4'h8) pc_d = valC;
        else if (icode_q == 4'h9)                        pc_d = valM;
        else                                             pc_d = valP;
        cnt_d   = cnt_q + 32'd1;
        state_d = S_FETCH;
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase

    // Strobes are registered from the upcoming state so they align with stage.
    fetch_req_d = (state_d == S_FETCH);
    dmem_req_d  = (state_d == S_MEMORY);
    dmem_wr_d   = dmem_req_d && mem_write(icode_d);
    wsel_d      = dmem_req_d && (icode_d == 4'h8);
    cc_we_d     = (state_d == S_EXECUTE) && (icode_d == 4'h6);
    rf_we_d     = (state_d == S_WRITEBACK) && reg_write(icode_d, Cnd);
  end

  assign fetch_req      = fetch_req_q;
  assign dmem_req       = dmem_req_q;
  assign dmem_wr        = dmem_wr_q;
  assign dmem_wdata_sel = wsel_q;
  assign cc_we          = cc_we_q;
  assign rf_we          = rf_we_q;
  assign stage          = state_q;
  assign pc             = pc_q;
  assign stat           = stat_q;
  assign instr_count    = cnt_q;

endmodule
